// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - hex segment table, blank pattern and slot-length helper for seven_seg_scan_ctrl
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high {g,f,e,d,c,b,a} patterns for 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int slot_cycles(input int clk_hz, input int fps, input int num_digits);
    return clk_hz / (fps * num_digits);
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// rtl/seven_seg_decoder.sv - combinational hex nibble to active-high seven-segment pattern
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - multiplexed N-digit seven-segment scanner with PWM dimming and dead time
// Optional blink support is built when the BLINK_EN macro is defined.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_HZ         = 100_000_000,
  parameter int FPS            = 50,
  parameter int BRIGHT_W       = 4,
  parameter int DEADTIME       = 2,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
`ifdef BLINK_EN
  ,
  parameter int BLINK_FRAMES   = 25
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dots_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [BRIGHT_W-1:0]     brightness,
`ifdef BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [6:0]              seg_out,
  output logic                    dot_out,
  output logic                    frame_start
);

  localparam int SLOT_CYC = slot_cycles(CLK_HZ, FPS, NUM_DIGITS);
  localparam int PRE_W    = $clog2(SLOT_CYC);
  localparam int SEL_W    = $clog2(NUM_DIGITS);
  localparam logic [PRE_W-1:0]    PRE_LAST    = PRE_W'(SLOT_CYC - 1);
  localparam logic [PRE_W-1:0]    DEAD_CYC    = PRE_W'(DEADTIME);
  localparam logic [SEL_W-1:0]    SEL_LAST    = SEL_W'(NUM_DIGITS - 1);
  localparam logic [BRIGHT_W-1:0] BRIGHT_FULL = '1;

  logic [PRE_W-1:0]      prescaler;
  logic [SEL_W-1:0]      sel, sel_next;
  logic [3:0]            slot_nib;
  logic                  slot_dot, slot_en;
  logic                  slot_tick, frame_wrap;
  logic [BRIGHT_W-1:0]   pwm;
  logic                  an_on;
  logic [NUM_DIGITS-1:0] an_lvl, blank_mask;
  logic [6:0]            dec_seg, seg_lvl;

  assign slot_tick  = (prescaler == PRE_LAST);
  assign frame_wrap = slot_tick && (sel == SEL_LAST);
  assign sel_next   = frame_wrap ? '0 : sel + 1'b1;

`ifdef BLINK_EN
  localparam int FC_W = $clog2(BLINK_FRAMES + 1);
  logic [FC_W-1:0] frame_cnt;
  logic            blink_phase, blink_phase_next;

  // New phase is visible to the slot-0 latch in the same wrap cycle
  assign blink_phase_next = (frame_wrap && frame_cnt == FC_W'(BLINK_FRAMES - 1)) ? ~blink_phase : blink_phase;
  assign blank_mask = blink_phase_next ? blink_mask : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_wrap) begin
      frame_cnt   <= (frame_cnt == FC_W'(BLINK_FRAMES - 1)) ? '0 : frame_cnt + 1'b1;
      blink_phase <= blink_phase_next;
    end
  end
`else
  assign blank_mask = '0;
`endif

  // Reset preloads digit 0 so the first slot after reset is a full, valid one
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      sel       <= '0;
      slot_nib  <= digits_in[3:0];
      slot_dot  <= dots_in[0];
      slot_en   <= digit_en[0];
    end else begin
      prescaler <= slot_tick ? '0 : prescaler + 1'b1;
      if (slot_tick) begin
        sel      <= sel_next;
        slot_nib <= digits_in[{sel_next, 2'b00} +: 4];
        slot_dot <= dots_in[sel_next];
        slot_en  <= digit_en[sel_next] & ~blank_mask[sel_next];
      end
    end
  end

  seven_seg_decoder u_decoder (
    .nibble (slot_nib),
    .seg    (dec_seg)
  );

  assign pwm     = BRIGHT_W'(prescaler - DEAD_CYC);
  assign an_on   = slot_en && (prescaler >= DEAD_CYC) &&
                   ((brightness == BRIGHT_FULL) || (pwm < brightness));
  assign seg_lvl = slot_en ? dec_seg : SEG_BLANK;

  always_comb begin
    an_lvl      = '0;
    an_lvl[sel] = an_on;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an_out      <= {NUM_DIGITS{AN_ACTIVE_LOW}};
      seg_out     <= {7{SEG_ACTIVE_LOW}};
      dot_out     <= SEG_ACTIVE_LOW;
      frame_start <= 1'b0;
    end else begin
      an_out      <= an_lvl ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
      seg_out     <= seg_lvl ^ {7{SEG_ACTIVE_LOW}};
      dot_out     <= (slot_en & slot_dot) ^ SEG_ACTIVE_LOW;
      frame_start <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - self-checking bench for seven_seg_scan_ctrl, both output polarities
module tb_seven_seg_scan_ctrl;

  localparam int ND = 4, SLOT = 8, DT = 1, BF = 2;
`ifdef BLINK_EN
  localparam bit HAS_BLINK = 1'b1;
`else
  localparam bit HAS_BLINK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] digits_in;
  logic [3:0]  dots_in, digit_en, blink_mask;
  logic [1:0]  brightness;
  logic [3:0]  an_lo, an_hi;
  logic [6:0]  seg_lo, seg_hi;
  logic        dot_lo, dot_hi, fs_lo, fs_hi;

  int vectors = 0;
  int miscompares = 0;

  int         cyc, frames;
  logic [3:0] m_nib [ND];
  logic       m_dot [ND];
  logic       m_en  [ND];
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dot, exp_fs;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS(ND), .CLK_HZ(1600), .FPS(50), .BRIGHT_W(2), .DEADTIME(DT),
    .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
`ifdef BLINK_EN
    , .BLINK_FRAMES(BF)
`endif
  ) u_lo (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dots_in(dots_in),
    .digit_en(digit_en), .brightness(brightness),
`ifdef BLINK_EN
    .blink_mask(blink_mask),
`endif
    .an_out(an_lo), .seg_out(seg_lo), .dot_out(dot_lo), .frame_start(fs_lo)
  );

  seven_seg_scan_ctrl #(
    .NUM_DIGITS(ND), .CLK_HZ(1600), .FPS(50), .BRIGHT_W(2), .DEADTIME(DT),
    .AN_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)
`ifdef BLINK_EN
    , .BLINK_FRAMES(BF)
`endif
  ) u_hi (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dots_in(dots_in),
    .digit_en(digit_en), .brightness(brightness),
`ifdef BLINK_EN
    .blink_mask(blink_mask),
`endif
    .an_out(an_hi), .seg_out(seg_hi), .dot_out(dot_hi), .frame_start(fs_hi)
  );

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Model works in absolute time: cycle index -> slot, digit, phase, frame
  task automatic step(input string tag);
    int p, d, dn;
    logic dark;
    if (reset) begin
      exp_an = '0; exp_seg = '0; exp_dot = 1'b0; exp_fs = 1'b0;
      cyc = 0; frames = 0;
      m_nib[0] = digits_in[3:0]; m_dot[0] = dots_in[0]; m_en[0] = digit_en[0];
    end else begin
      p = cyc % SLOT;
      d = (cyc / SLOT) % ND;
      exp_an = '0;
      if (p >= DT && m_en[d] && (brightness == 2'b11 || ((p - DT) % 4) < int'(brightness)))
        exp_an[d] = 1'b1;
      exp_seg = m_en[d] ? hex7(m_nib[d]) : 7'h00;
      exp_dot = m_en[d] & m_dot[d];
      exp_fs  = 1'b0;
      if (p == SLOT - 1) begin
        dn = (d + 1) % ND;
        if (dn == 0) begin
          frames++;
          exp_fs = 1'b1;
        end
        dark = HAS_BLINK && ((frames / BF) % 2 == 1);
        m_nib[dn] = digits_in[4*dn +: 4];
        m_dot[dn] = dots_in[dn];
        m_en[dn]  = digit_en[dn] && !(dark && blink_mask[dn]);
      end
      cyc++;
    end
    @(posedge clk);
    #1;
    vectors++;
    assert ({an_lo, seg_lo, dot_lo, fs_lo} === {~exp_an, ~exp_seg, ~exp_dot, exp_fs}) else begin
      miscompares++;
      $error("FAIL %s lo cyc=%0d: got an=%b seg=%h dot=%b fs=%b want an=%b seg=%h dot=%b fs=%b",
             tag, cyc, an_lo, seg_lo, dot_lo, fs_lo, ~exp_an, ~exp_seg, ~exp_dot, exp_fs);
    end
    vectors++;
    assert ({an_hi, seg_hi, dot_hi, fs_hi} === {exp_an, exp_seg, exp_dot, exp_fs}) else begin
      miscompares++;
      $error("FAIL %s hi cyc=%0d: got an=%b seg=%h dot=%b fs=%b want an=%b seg=%h dot=%b fs=%b",
             tag, cyc, an_hi, seg_hi, dot_hi, fs_hi, exp_an, exp_seg, exp_dot, exp_fs);
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic run_until(input int modulus, input int phase, input string tag);
    for (int i = 0; i < 64 && (cyc % modulus) != phase; i++) step(tag);
  endtask

  initial begin
    reset = 1'b1; digits_in = 16'h3210; dots_in = 4'b0000; digit_en = 4'b1111;
    brightness = 2'b11; blink_mask = 4'b0000;
    run(5, "reset");
    vectors++;
    assert ({an_lo, seg_lo, dot_lo, fs_lo} === {4'b1111, 7'h7F, 1'b1, 1'b0}) else begin
      miscompares++;
      $error("FAIL reset_pins: got %b %h %b %b want 1111 7f 1 0", an_lo, seg_lo, dot_lo, fs_lo);
    end
    reset = 1'b0;
    run(64, "scan_full");
    brightness = 2'b01; run(32, "bright1");
    brightness = 2'b00; run(32, "bright0");
    brightness = 2'b11; digit_en = 4'b1011; run(32, "blank");
    digit_en = 4'b1111;
    run_until(32, 3, "to_slot0");
    digits_in[3:0] = 4'h8; run(40, "latch");
    digits_in = 16'h3211; dots_in = 4'b0001; run(32, "dot");
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        digits_in  = 16'($urandom);
        dots_in    = 4'($urandom);
        digit_en   = 4'($urandom);
        brightness = 2'($urandom);
        blink_mask = 4'($urandom);
      end
      step("random");
    end
    run_until(8, 3, "to_mid");
    reset = 1'b1; step("mid_reset");
    reset = 1'b0; run(40, "after_reset");
    digits_in = 16'hA5C7; dots_in = 4'b1010; digit_en = 4'b1111; brightness = 2'b11;
    blink_mask = 4'b0001;
    reset = 1'b1; run(2, "blink_reset");
    reset = 1'b0; run(5 * 32, "blink");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Parametrised N-digit multiplexed seven-segment driver. Time-slices one shared segment bus across NUM_DIGITS common-anode/cathode digits at a programmable frame rate. Supports per-digit enable, global PWM brightness, inter-digit dead time and selectable output polarity. Sits between register/datapath logic producing hex nibbles and the board's display pins.

Parameters:
NUM_DIGITS, 4, digits scanned (2..16)
CLK_HZ, 100_000_000, input clock frequency
FPS, 50, full-frame refresh rate; slot length SLOT_CYC = CLK_HZ/(FPS*NUM_DIGITS), integer-truncated, must be >= 2^BRIGHT_W + DEADTIME
BRIGHT_W, 4, brightness/PWM counter width
DEADTIME, 2, cycles per slot with all anodes inactive (anti-ghosting)
AN_ACTIVE_LOW, 1, 1 = an_out low selects digit
SEG_ACTIVE_LOW, 1, 1 = seg_out/dot_out low lights segment

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
digits_in  in  4*NUM_DIGITS  hex nibble per digit; digit i = bits [4i+3:4i]
dots_in  in  NUM_DIGITS  decimal point per digit
digit_en  in  NUM_DIGITS  1 = digit displayed, 0 = blanked
brightness  in  BRIGHT_W  on-duty within PWM period; 0 = dark, all-ones = full on
an_out  out  NUM_DIGITS  digit selects, polarity per AN_ACTIVE_LOW
seg_out  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
dot_out  out  1  decimal point, polarity per SEG_ACTIVE_LOW
frame_start  out  1  one-cycle pulse when scan returns to digit 0

Behaviour:
- Reset (sync, priority over all): prescaler=0, sel=0, pwm=0; an_out all inactive, seg_out/dot_out all unlit, frame_start=0.
- Prescaler counts 0..SLOT_CYC-1; slot_tick asserted in the cycle it equals SLOT_CYC-1, then wraps to 0.
- On slot_tick: sel <= (sel==NUM_DIGITS-1) ? 0 : sel+1; nibble, dot and enable of the next digit latched into slot registers (mid-slot input changes invisible until next slot of that digit).
- frame_start = 1 in the cycle after the tick that wraps sel to 0.
- Slot phase p = prescaler value. For p < DEADTIME: all anodes inactive.
- For p >= DEADTIME: pwm = (p-DEADTIME) mod 2^BRIGHT_W; anode sel active iff slot_en && (brightness == all-ones || pwm < brightness).
- Segment data decoded from latched nibble; seg_out/dot_out held valid for the whole slot, independent of PWM.
- All outputs registered: 1-cycle latency from internal state to pins. At most one anode active in any cycle.
- Digit i drives an_out[i]; digit 0 is leftmost.
- Polarity applied at output register only; internal logic active-high.
- digit_en[i]=0: slot still consumed (fixed frame timing), anode stays inactive, segments unlit.
- reset asserted mid-slot: outputs inactive next cycle; scan restarts at digit 0 with a full slot.

Optional Feature:
BLINK_EN: adds input blink_mask [NUM_DIGITS-1:0] and parameter BLINK_FRAMES (default 25). A frame counter toggles blink_phase every BLINK_FRAMES frame_start pulses; while blink_phase=1, digits with blink_mask[i]=1 are blanked exactly as digit_en=0. blink_phase=0 and counter=0 on reset. Without macro: no port, no counter, behaviour as above.

Decomposition:
- Package seven_seg_pkg: 16-entry hex segment pattern constant (active-high), slot-length function, SEG_BLANK constant.
- One sub-module: seven_seg_decoder (combinational nibble -> 7-bit active-high pattern), instantiated once on the latched nibble.

Test Plan:
- Reset: params NUM_DIGITS=4, CLK_HZ=1600, FPS=50 (SLOT_CYC=8), BRIGHT_W=2, DEADTIME=1; hold reset 5 cycles -> an_out=4'b1111, seg_out=7'h7F, dot_out=1, frame_start=0.
- Scan order: digits_in=16'h3210, all enabled, brightness=2'b11 -> an_out sequence 1110,1101,1011,0111 each active 7 of 8 cycles; seg_out for digit0=~7'h3F; frame_start pulses every 32 cycles.
- Brightness: brightness=1 -> each anode active 2 of 8 cycles per slot (pwm=0 in phases 1 and 5); brightness=0 -> an_out constant 4'b1111.
- Blanking/latching: digit_en=4'b1011 -> an_out never 1011; change digits_in[3:0] to 4'h8 mid-slot 0 -> seg_out unchanged until next slot 0, then ~7'h7F.
- Polarity: AN_ACTIVE_LOW=0, SEG_ACTIVE_LOW=0, digit 0 = 4'h1, dot set -> an_out=0001 during slot 0, seg_out=7'h06, dot_out=1.
- BLINK_EN: BLINK_FRAMES=2, blink_mask=4'b0001 -> digit 0 visible frames 0-1, dark frames 2-3, repeating; other digits unaffected.
